tiny_dmem_responder: RTL and testbench

// - Data-memory responder for tiny_cpu load/store traffic. It is the slave end of the CPU's LW/SW request interface.
// - Holds a word-organised RAM array RAM[0:WORDS-1] and accepts one request at a time over a valid/ready handshake.
// - Applies programmable wait states, then returns read data or commits byte-lane write data.

---
 rtl/tiny_dmem_responder.sv | 168 ++++++++++++++++
 tb/tb_tiny_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_dmem_responder.sv
// tiny_dmem_responder: data-memory slave for tiny_cpu LW/SW traffic.
// Holds a WORDS x 32-bit RAM and serves one request at a time over a valid/ready
// handshake. After WAIT_STATES wait cycles it either returns the addressed word or
// commits byte-lane write data and returns the merged word.
//
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag addresses beyond the RAM
// (mem_err=1, mem_rdata=0, no write). Without it, upper address bits alias.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESETN     in   asynchronous active-low reset (RAM contents kept)
//   mem_valid  in   request present, held by initiator until mem_ready
//   mem_addr   in   byte address, bits [1:0] ignored
//   mem_wdata  in   store data, little-endian byte lanes
//   mem_wstrb  in   byte write enables, 4'b0000 = load
//   mem_ready  out  one-cycle response strobe
//   mem_rdata  out  load data, held until the next response
//   mem_err    out  out-of-range flag, qualified by mem_ready
module tiny_dmem_responder #(
  parameter int unsigned WORDS       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int unsigned IdxW = $clog2(WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              oob_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       ram_q [WORDS];

  logic              accept;
  logic              commit;
  logic [IdxW-1:0]   req_idx;
  logic              req_oob;
  logic [IdxW-1:0]   cmt_idx;
  logic              cmt_oob;
  logic [31:0]       cmt_wdata;
  logic [3:0]        cmt_wstrb;
  logic [31:0]       cur_word;
  logic [31:0]       merged;
  logic              unused_addr;

  assign req_idx = mem_addr[IdxW+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign req_oob     = |mem_addr[31:IdxW+2];
  assign unused_addr = ^mem_addr[1:0];
`else
  assign req_oob     = 1'b0;
  assign unused_addr = ^{mem_addr[31:IdxW+2], mem_addr[1:0]};
`endif

  assign accept = (state_q == StIdle) && mem_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        // The edge that brings the counter to zero is the one entering RESP.
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the commit happens on the accept edge itself, so the
  // request must come straight from the port instead of the latched copy.
  always_comb begin
    if (state_q == StIdle) begin
      cmt_idx   = req_idx;
      cmt_oob   = req_oob;
      cmt_wdata = mem_wdata;
      cmt_wstrb = mem_wstrb;
    end else begin
      cmt_idx   = idx_q;
      cmt_oob   = oob_q;
      cmt_wdata = wdata_q;
      cmt_wstrb = wstrb_q;
    end
  end

  assign cur_word = ram_q[cmt_idx];

  always_comb begin
    merged = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (cmt_wstrb[b]) begin
        merged[8*b +: 8] = cmt_wdata[8*b +: 8];
      end
    end
  end

  // RAM is written in the else branch only, so a reset edge can never commit.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      oob_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= req_idx;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        oob_q   <= req_oob;
      end
      if (commit) begin
        rdata_q <= cmt_oob ? 32'd0 : merged;
        err_q   <= cmt_oob;
        if (!cmt_oob && (|cmt_wstrb)) begin
          ram_q[cmt_idx] <= merged;
        end
      end
    end
  end

  assign mem_ready = (state_q == StResp);
  assign mem_rdata = rdata_q;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign mem_err   = err_q;
`else
  assign mem_err   = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_tiny_dmem_responder.sv
// Bench for tiny_dmem_responder: three instances (WAIT_STATES 2, 0, 3) share the
// address/data/strobe inputs, each with its own mem_valid, and are compared to a
// word-array reference model.
module tb_tiny_dmem_responder;

  localparam int unsigned TbWords = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [2:0]  ready;
  logic [2:0]  err;
  logic [31:0] rdata [3];

  int cmp = 0;
  int mis = 0;

  logic [31:0] model_ram [TbWords];
  logic [2:0]  ready_prev = 3'b000;

  always #5 clk = ~clk;

  tiny_dmem_responder #(.WORDS(256), .WAIT_STATES(2)) u_dut_w2 (
    .CLK(clk), .RESETN(rst_n), .mem_valid(valid[0]), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mem_ready(ready[0]), .mem_rdata(rdata[0]), .mem_err(err[0])
  );

  tiny_dmem_responder #(.WORDS(256), .WAIT_STATES(0)) u_dut_w0 (
    .CLK(clk), .RESETN(rst_n), .mem_valid(valid[1]), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mem_ready(ready[1]), .mem_rdata(rdata[1]), .mem_err(err[1])
  );

  tiny_dmem_responder #(.WORDS(256), .WAIT_STATES(3)) u_dut_w3 (
    .CLK(clk), .RESETN(rst_n), .mem_valid(valid[2]), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mem_ready(ready[2]), .mem_rdata(rdata[2]), .mem_err(err[2])
  );

  function automatic int wait_of(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // mem_ready must never be high on two consecutive cycles.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ready[k]) begin
        cmp++;
        if (ready_prev[k]) begin
          mis++;
          $display("FAIL ready_double dut%0d: ready high 2 cycles, required 1", k);
        end
      end
    end
    ready_prev <= ready;
  end

  // Reference: word index is the byte address / 4 modulo the depth; out-of-range
  // (bounds build only) means any address bit above the RAM is set.
  task automatic model_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] exp_d, output logic exp_e);
    int  idx;
    bit  oob;
    idx = int'((a / 4) % TbWords);
`ifdef DMEM_BOUNDS_CHECK_EN
    oob = (a / (4 * TbWords)) != 0;
`else
    oob = 1'b0;
`endif
    if (oob) begin
      exp_d = 32'd0;
      exp_e = 1'b1;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model_ram[idx][8*b +: 8] = d[8*b +: 8];
      end
      exp_d = model_ram[idx];
      exp_e = 1'b0;
    end
  endtask

  // One transaction issued to all three instances at once.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit scramble, input string tag);
    logic [31:0] exp_d;
    logic        exp_e;
    bit   [2:0]  done;
    model_op(a, d, s, exp_d, exp_e);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wstrb = s;
    valid = 3'b111;
    @(posedge clk);
    #1;
    if (scramble) begin
      addr  = $urandom;
      wdata = $urandom;
      wstrb = 4'($urandom);
      valid = 3'b000;
    end
    done = 3'b000;
    for (int cyc = 1; cyc <= 40 && done != 3'b111; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!done[k] && ready[k]) begin
          done[k]  = 1'b1;
          valid[k] = 1'b0;
          cmp++;
          if (cyc != wait_of(k) + 1) begin
            mis++;
            $display("FAIL %s latency dut%0d: got %0d cycles, required %0d", tag, k, cyc,
                     wait_of(k) + 1);
          end
          cmp++;
          if (rdata[k] !== exp_d) begin
            mis++;
            $display("FAIL %s rdata dut%0d: got %08h, required %08h", tag, k, rdata[k], exp_d);
          end
          cmp++;
          if (err[k] !== exp_e) begin
            mis++;
            $display("FAIL %s err dut%0d: got %0b, required %0b", tag, k, err[k], exp_e);
          end
        end
      end
    end
    cmp++;
    if (done != 3'b111) begin
      mis++;
      $display("FAIL %s timeout: responded %03b, required 111", tag, done);
    end
    valid = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 3'b000;
    addr  = 32'd0;
    wdata = 32'd0;
    wstrb = 4'd0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cmp++;
      if (ready[k] !== 1'b0) begin
        mis++;
        $display("FAIL reset ready dut%0d: got %0b, required 0", k, ready[k]);
      end
      cmp++;
      if (rdata[k] !== 32'd0) begin
        mis++;
        $display("FAIL reset rdata dut%0d: got %08h, required 0", k, rdata[k]);
      end
      cmp++;
      if (err[k] !== 1'b0) begin
        mis++;
        $display("FAIL reset err dut%0d: got %0b, required 0", k, err[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sw_lw();
    do_txn(32'h0, 32'h0000_002A, 4'hF, 1'b0, "sw0");
    do_txn(32'h0, 32'hFFFF_FFFF, 4'h0, 1'b0, "lw0");
  endtask

  task automatic test_byte_lanes();
    do_txn(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, "lane_full");
    do_txn(32'h10, 32'h0000_AA00, 4'b0010, 1'b0, "lane_b1");
    do_txn(32'h10, 32'h0, 4'h0, 1'b0, "lane_rd");
  endtask

  task automatic test_init_words();
    for (int i = 0; i < 16; i++) begin
      if (i != 0 && i != 4) do_txn(32'(i * 4), $urandom, 4'hF, 1'b0, "init");
    end
  endtask

  task automatic test_bounds();
    do_txn(32'h400, 32'h0000_0055, 4'hF, 1'b0, "bnd_wr");
    do_txn(32'h0, 32'h0, 4'h0, 1'b0, "bnd_rd0");
    do_txn(32'h404, 32'h0, 4'h0, 1'b0, "bnd_rd_hi");
  endtask

  // Only the WAIT_STATES=2 instance: valid held across three reads.
  task automatic test_back_to_back();
    int n;
    int last;
    n    = 0;
    last = 0;
    @(negedge clk);
    addr  = 32'h0;
    wstrb = 4'h0;
    valid = 3'b001;
    for (int cyc = 1; cyc <= 60 && n < 3; cyc++) begin
      @(negedge clk);
      if (ready[0]) begin
        cmp++;
        if (rdata[0] !== model_ram[n]) begin
          mis++;
          $display("FAIL b2b rdata #%0d: got %08h, required %08h", n, rdata[0], model_ram[n]);
        end
        if (n > 0) begin
          cmp++;
          if (cyc - last != 4) begin
            mis++;
            $display("FAIL b2b spacing #%0d: got %0d cycles, required 4", n, cyc - last);
          end
        end
        last = cyc;
        n++;
        addr = 32'(n * 4);
        if (n == 3) valid = 3'b000;
      end
    end
    valid = 3'b000;
    cmp++;
    if (n != 3) begin
      mis++;
      $display("FAIL b2b timeout: got %0d responses, required 3", n);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    addr  = 32'h20;
    wdata = 32'h0000_1234;
    wstrb = 4'hF;
    valid = 3'b001;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    valid = 3'b000;
    #1;
    cmp++;
    if (ready[0] !== 1'b0 || rdata[0] !== 32'd0 || err[0] !== 1'b0) begin
      mis++;
      $display("FAIL rst_mid outputs: got ready=%0b rdata=%08h err=%0b, required all 0",
               ready[0], rdata[0], err[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp++;
      if (ready[0] !== 1'b0) begin
        mis++;
        $display("FAIL rst_mid ready cycle %0d: got 1, required 0", i);
      end
    end
    do_txn(32'h20, 32'h0, 4'h0, 1'b0, "rst_mid_rd");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  s;
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 7)) << 10);
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      do_txn(a, $urandom, s, 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_byte_lanes();
    test_init_words();
    test_bounds();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
